// File: rtl/cr_huf_comp_st_packer_if.sv
// cr_huf_comp_st_packer_if: symbol beat input, LUT write port and table status.
// master drives beats and control, slave is the packer.
interface cr_huf_comp_st_packer_if #(
  parameter int LANES     = 4,
  parameter int WORD_W    = 64,
  parameter int CODE_W    = 27,
  parameter int EXTRA_W   = 8,
  parameter int MAX_WORDS = 73
);
  localparam int ADDR_W = $clog2(MAX_WORDS);
  localparam int CL_W   = $clog2(CODE_W + 1);
  localparam int EL_W   = $clog2(EXTRA_W + 1);
  localparam int TB_W   = ADDR_W + $clog2(WORD_W) + 1;

  logic                     start;
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0]         in_lane_val;
  logic [LANES*CODE_W-1:0]  in_code;
  logic [LANES*CL_W-1:0]    in_code_len;
  logic [LANES*EXTRA_W-1:0] in_extra;
  logic [LANES*EL_W-1:0]    in_extra_len;
  logic                     in_last;
  logic                     wr;
  logic [ADDR_W-1:0]        wr_addr;
  logic [WORD_W-1:0]        wr_data;
  logic                     wr_done;
  logic                     wr_abort;
  logic                     overflow;
  logic [TB_W-1:0]          total_bits;

  modport master (
    output start, abort, in_valid, in_lane_val, in_code,
    output in_code_len, in_extra, in_extra_len, in_last,
    input  in_ready, wr, wr_addr, wr_data, wr_done,
    input  wr_abort, overflow, total_bits
  );

  modport slave (
    input  start, abort, in_valid, in_lane_val, in_code,
    input  in_code_len, in_extra, in_extra_len, in_last,
    output in_ready, wr, wr_addr, wr_data, wr_done,
    output wr_abort, overflow, total_bits
  );
endinterface

// File: rtl/cr_huf_comp_st_packer.sv
// cr_huf_comp_st_packer: packs per-lane code/extra symbols LSB-first into LUT words.
// Define CR_HUF_COMP_ST_PACKER_BITREV_EN to bit-reverse each code within its length.
module cr_huf_comp_st_packer #(
  parameter int LANES     = 4,
  parameter int WORD_W    = 64,
  parameter int CODE_W    = 27,
  parameter int EXTRA_W   = 8,
  parameter int MAX_WORDS = 73
) (
  input logic clk,
  input logic rst,
  cr_huf_comp_st_packer_if.slave bus
);
  localparam int ADDR_W = $clog2(MAX_WORDS);
  localparam int CL_W   = $clog2(CODE_W + 1);
  localparam int EL_W   = $clog2(EXTRA_W + 1);
  localparam int TB_W   = ADDR_W + $clog2(WORD_W) + 1;
  localparam int BEAT_W = LANES * (CODE_W + EXTRA_W);
  localparam int ACC_W  = WORD_W + BEAT_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int BLEN_W = $clog2(BEAT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_d;

  logic [ACC_W-1:0]   acc, acc_d, merged;
  logic [FILL_W-1:0]  fill, fill_d, mfill;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic               full, full_d;

  logic [CODE_W-1:0]  raw   [LANES];
  logic [CODE_W-1:0]  lcode [LANES];
  logic [EXTRA_W-1:0] lext  [LANES];
  logic [CL_W-1:0]    lcl   [LANES];
  logic [EL_W-1:0]    lel   [LANES];
`ifdef CR_HUF_COMP_ST_PACKER_BITREV_EN
  logic [CODE_W-1:0]  rev   [LANES];
`endif

  logic [BEAT_W-1:0]  beat;
  logic [BLEN_W-1:0]  blen;
  logic               kill, restart, accept, emit;
  logic [TB_W:0]      tsum;

  logic               ready_d, wr_d, done_d, abort_d, ovf_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [WORD_W-1:0]  wr_data_d;
  logic [TB_W-1:0]    tb_d;

  // invalid lanes collapse to zero length, so they occupy no bits
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lcl[l] = bus.in_code_len[l*CL_W +: CL_W];
      lel[l] = bus.in_extra_len[l*EL_W +: EL_W];
      if (lcl[l] > CL_W'(CODE_W)) lcl[l] = CL_W'(CODE_W);
      if (lel[l] > EL_W'(EXTRA_W)) lel[l] = EL_W'(EXTRA_W);
      if (!bus.in_lane_val[l]) begin
        lcl[l] = '0;
        lel[l] = '0;
      end
      raw[l] = bus.in_code[l*CODE_W +: CODE_W];
`ifdef CR_HUF_COMP_ST_PACKER_BITREV_EN
      rev[l]   = {<<{raw[l]}};
      lcode[l] = rev[l] >> (CL_W'(CODE_W) - lcl[l]);
`else
      lcode[l] = raw[l] & ({CODE_W{1'b1}} >> (CL_W'(CODE_W) - lcl[l]));
`endif
      lext[l] = bus.in_extra[l*EXTRA_W +: EXTRA_W]
              & ({EXTRA_W{1'b1}} >> (EL_W'(EXTRA_W) - lel[l]));
    end
  end

  always_comb begin
    beat = '0;
    blen = '0;
    for (int l = 0; l < LANES; l++) begin
      beat = beat | (BEAT_W'(lcode[l]) << blen);
      blen = blen + BLEN_W'(lcl[l]);
      beat = beat | (BEAT_W'(lext[l]) << blen);
      blen = blen + BLEN_W'(lel[l]);
    end
  end

  assign kill    = bus.abort & (state != IDLE);
  assign restart = bus.start & ~bus.abort & (state != FLUSH);
  assign accept  = bus.in_valid & bus.in_ready & ~kill & ~restart;
  assign merged  = accept ? (acc | (ACC_W'(beat) << fill)) : acc;
  assign mfill   = accept ? (fill + FILL_W'(blen)) : fill;
  assign emit    = (state != IDLE) & ~kill & ~restart
                 & ((mfill >= FILL_W'(WORD_W))
                 | ((state == FLUSH) & (mfill != '0)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (restart) state_d = RUN;
      RUN: begin
        if (kill) state_d = IDLE;
        else if (accept & bus.in_last) state_d = FLUSH;
      end
      FLUSH: if (kill || mfill < FILL_W'(WORD_W)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = merged;
    fill_d    = mfill;
    addr_d    = addr;
    full_d    = full;
    wr_d      = 1'b0;
    wr_addr_d = bus.wr_addr;
    wr_data_d = bus.wr_data;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    ovf_d     = bus.overflow;
    tb_d      = bus.total_bits;
    tsum      = {1'b0, bus.total_bits} + (TB_W+1)'(accept ? blen : '0);
    if (accept) tb_d = tsum[TB_W] ? '1 : tsum[TB_W-1:0];
    if (emit) begin
      if (mfill >= FILL_W'(WORD_W)) begin
        acc_d  = merged >> WORD_W;
        fill_d = mfill - FILL_W'(WORD_W);
      end else begin
        acc_d  = '0;
        fill_d = '0;
      end
      // past the last LUT word the data is dropped but packing goes on
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_d      = 1'b1;
        wr_addr_d = addr;
        wr_data_d = merged[WORD_W-1:0];
        if (addr == ADDR_W'(MAX_WORDS - 1)) full_d = 1'b1;
        else addr_d = addr + ADDR_W'(1);
      end
    end
    if (state == FLUSH && !kill && mfill < FILL_W'(WORD_W)) done_d = 1'b1;
    unique case (1'b1)
      kill: begin
        acc_d   = '0;
        fill_d  = '0;
        done_d  = 1'b1;
        abort_d = 1'b1;
      end
      restart: begin
        acc_d     = '0;
        fill_d    = '0;
        addr_d    = '0;
        full_d    = 1'b0;
        wr_addr_d = '0;
        ovf_d     = 1'b0;
        tb_d      = '0;
      end
      default: ;
    endcase
    ready_d = (state_d == RUN) & (fill_d < FILL_W'(WORD_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      fill           <= '0;
      addr           <= '0;
      full           <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.wr         <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.wr_done    <= 1'b0;
      bus.wr_abort   <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.total_bits <= '0;
    end else begin
      acc            <= acc_d;
      fill           <= fill_d;
      addr           <= addr_d;
      full           <= full_d;
      bus.in_ready   <= ready_d;
      bus.wr         <= wr_d;
      bus.wr_addr    <= wr_addr_d;
      bus.wr_data    <= wr_data_d;
      bus.wr_done    <= done_d;
      bus.wr_abort   <= abort_d;
      bus.overflow   <= ovf_d;
      bus.total_bits <= tb_d;
    end
  end
endmodule
